led_seq_core: RTL
=================

LED_SEQ_CORE -- requirements
Module: led_seq_core

Interface
REQ-001 Parameter ADDR_W, default 8, program address width in bits.
REQ-002 Parameter PAT_W, default 8, LED pattern width in bits (1..8).
REQ-003 Parameter TICK_DIV, default 3_125_000, clk cycles per timing tick (>=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 run  input  1  1 = sequencer advances; 0 = all state frozen.
REQ-007 addrRd  output  ADDR_W  program RAM read address, registered.
REQ-008 dataRd  input  16  instruction word; valid one cycle after addrRd changes.
REQ-009 outPattern  output  PAT_W  LED drive, registered.
REQ-010 halted  output  1  high while in HALT state.
REQ-011 illegal  output  1  sticky flag, set on an undefined opcode.

Function
REQ-012 Instruction fields: op = dataRd[15:12], arg = dataRd[11:8], imm = dataRd[7:0].
REQ-013 Opcode 0 NOP: pc <= pc+1.
REQ-014 Opcode 1 SHOW: outPattern <= imm[PAT_W-1:0], hold for arg+1 ticks, then pc <= pc+1.
REQ-015 Opcode 2 JUMP: pc <= imm[ADDR_W-1:0], zero-extended if ADDR_W > 8.
REQ-016 Opcode 3 SETL: 8-bit loop counter lc <= imm; pc <= pc+1.
REQ-017 Opcode 4 DJNZ: lc <= lc-1 (mod 256); if the decremented value != 0, pc <= imm, else pc <= pc+1.
REQ-018 DJNZ with lc == 0 decrements to 255 and jumps (wrap, no saturation).
REQ-019 Opcode 5 HALT: enter HALT; remain there until reset; outPattern holds.
REQ-020 Opcodes 6..15: executed as NOP and set illegal (sticky until reset).
REQ-021 pc+1 wraps from 2^ADDR_W-1 to 0; addrRd always equals pc.
REQ-022 FSM states FETCH, EXEC, WAIT, HALT.
REQ-023 FETCH: one cycle for RAM latency -> EXEC.
REQ-024 EXEC: decode dataRd; SHOW -> WAIT; HALT -> HALT; all other opcodes -> FETCH with the new pc.
REQ-025 Non-SHOW instructions take exactly 2 cycles (FETCH + EXEC).
REQ-026 Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick on the terminal count.
REQ-027 Prescaler is cleared on entry to WAIT.
REQ-028 WAIT: decrement the tick counter on each tick; after the (arg+1)th tick, pc <= pc+1 -> FETCH.
REQ-029 SHOW outPattern updates at the EXEC clock edge, not at the end of WAIT.
REQ-030 run = 0: FSM, pc, lc, prescaler and tick counter hold; outputs hold.
REQ-031 run = 0: an in-progress WAIT resumes exactly where it stopped when run returns to 1.
REQ-032 run has no effect in HALT.

Reset
REQ-033 Asynchronous assertion of rst = 0 forces state FETCH and clears pc, addrRd, outPattern, lc, prescaler, tick counter, halted and illegal to 0.
REQ-034 Reset mid-WAIT or mid-HALT aborts the instruction; execution restarts at address 0 on the first clk edge after deassertion.

Structure
REQ-035 Opcode constants, field positions and the FSM state encoding shall reside in the shared package led_seq_pkg.
REQ-036 The prescaler shall be a single sub-module, led_tick_gen (parameter TICK_DIV; inputs clk, rst, clr, en; output tick).
REQ-037 No other sub-modules are used; the program RAM is external.

Verification (TICK_DIV = 4, synchronous RAM model with 1-cycle latency)
REQ-038 Program {SHOW arg=2 imm=0xA5; HALT} -> outPattern = 0xA5 from cycle 3, halted rises 12 cycles after the EXEC edge + 2, addrRd = 1 at halt.
REQ-039 Program {SETL 3; SHOW 0 0x01; DJNZ 1; SHOW 0 0xFF; HALT} -> exactly 3 0x01 pulses, then 0xFF, then halted = 1.
REQ-040 A JUMP to 0xFF followed by NOP at 0xFF -> addrRd wraps to 0x00.
REQ-041 Opcode 0xF at address 0 -> illegal = 1, pc = 1, illegal stays 1 through later instructions until rst.
REQ-042 run = 0 for 10 cycles mid-WAIT -> total SHOW duration extends by exactly 10 cycles; outPattern unchanged.
REQ-043 rst pulsed low mid-WAIT (asynchronous, between clock edges) -> outputs 0 immediately; refetch from address 0.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: instruction fields,
// opcodes and the controller state encoding.
package led_seq_pkg;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int ARG_MSB = 11;
    localparam int ARG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_SHOW = 4'h1;
    localparam logic [3:0] OP_JUMP = 4'h2;
    localparam logic [3:0] OP_SETL = 4'h3;
    localparam logic [3:0] OP_DJNZ = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h5;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/led_seq_if.sv
// Program RAM read bus between the sequencer (master) and external RAM (slave).
interface led_seq_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] addrRd;
    logic [15:0]       dataRd;

    modport master (output addrRd, input dataRd);
    modport slave  (input addrRd, output dataRd);
endinterface

// File: rtl/led_tick_gen.sv
// Timing prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// terminal count for one cycle. clr restarts the count from zero.
module led_tick_gen #(
    parameter int TICK_DIV = 3_125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    // Prescale counter; clear wins over enable so a new wait starts aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/led_seq_core.sv
// LED pattern sequencer: fetches 16-bit instructions from external RAM and
// drives a registered LED pattern with tick-timed hold periods.
//
//   state    | meaning
//   FETCH    | addrRd = pc presented, wait one cycle for RAM data
//   EXEC     | decode dataRd, update pc/lc/pattern
//   WAIT     | SHOW hold, counting arg+1 prescaler ticks
//   HALT     | stopped until reset, pattern holds
module led_seq_core
    import led_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PAT_W    = 8,
    parameter int TICK_DIV = 3_125_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    led_seq_if.master        bus,
    output logic [PAT_W-1:0] outPattern,
    output logic             halted,
    output logic             illegal
);
    seq_state_t        state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        lc;
    logic [3:0]        tcnt;

    logic [3:0]        op;
    logic [3:0]        arg;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic [7:0]        lc_dec;
    logic              tick;
    logic              tick_clr;
    logic              tick_en;

    assign op       = bus.dataRd[OP_MSB:OP_LSB];
    assign arg      = bus.dataRd[ARG_MSB:ARG_LSB];
    assign imm      = bus.dataRd[IMM_MSB:IMM_LSB];
    assign imm_addr = ADDR_W'(imm);
    assign pc_inc   = pc + ADDR_W'(1);
    assign lc_dec   = lc - 8'd1;

    // The RAM address is the program counter itself, so it is registered.
    assign bus.addrRd = pc;

    assign tick_clr = (state == ST_EXEC) && run && (op == OP_SHOW);
    assign tick_en  = (state == ST_WAIT) && run;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Sequencer FSM with registered outputs; run = 0 freezes all progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FETCH;
            pc         <= '0;
            lc         <= '0;
            tcnt       <= '0;
            outPattern <= '0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (run) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (run) begin
                        state <= ST_FETCH;
                        case (op)
                            OP_NOP:  pc <= pc_inc;
                            OP_SHOW: begin
                                outPattern <= PAT_W'(imm);
                                tcnt       <= arg;
                                state      <= ST_WAIT;
                            end
                            OP_JUMP: pc <= imm_addr;
                            OP_SETL: begin
                                lc <= imm;
                                pc <= pc_inc;
                            end
                            OP_DJNZ: begin
                                // lc == 0 wraps to 255 and keeps looping.
                                lc <= lc_dec;
                                pc <= (lc_dec != 8'd0) ? imm_addr : pc_inc;
                            end
                            OP_HALT: begin
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end
                            default: begin
                                illegal <= 1'b1;
                                pc      <= pc_inc;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (tcnt == 4'd0) begin
                            pc    <= pc_inc;
                            state <= ST_FETCH;
                        end else begin
                            tcnt <= tcnt - 4'd1;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule
